// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, fixed XLEN+1 cycle latency for every operation.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [4:0]      rw,
  output logic [XLEN-1:0] din
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [CW-1:0]       cnt_r;
  logic [2:0]          op_r;
  logic [4:0]          rd_r;
  logic                neg_r;
  logic                divz_r;
  logic [XLEN-1:0]     bmag_r;
  logic [2*XLEN-1:0]   work_r;
  logic                busy_r, done_r, we_r;
  logic [4:0]          rw_r;
  logic [XLEN-1:0]     din_r;

  logic                sa_s, sb_s, neg_s, last_s;
  logic [XLEN-1:0]     amag_s, bmag_s;
  logic [XLEN:0]       mul_sum_s, div_hi_s, div_diff_s;
  logic [2*XLEN-1:0]   work_nx_s, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, result_s;

  assign busy = busy_r;
  assign done = done_r;
  assign we   = we_r;
  assign rw   = rw_r;
  assign din  = din_r;

  assign last_s = (cnt_r == CW'(XLEN - 1));

  // Operand sign interpretation and magnitudes at request time
  always_comb begin
    sa_s = 1'b0;
    sb_s = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sa_s = a[XLEN-1];
        sb_s = b[XLEN-1];
      end
      OP_MULHSU: sa_s = a[XLEN-1];
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    amag_s = sa_s ? -a : a;
    bmag_s = sb_s ? -b : b;
    // A remainder follows the dividend sign; everything else follows the product of signs.
    neg_s  = (op == OP_REM) ? sa_s : (sa_s ^ sb_s);
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    work_nx_s  = work_r;
    mul_sum_s  = {1'b0, work_r[2*XLEN-1:XLEN]} + (work_r[0] ? {1'b0, bmag_r} : {(XLEN+1){1'b0}});
    div_hi_s   = work_r[2*XLEN-1:XLEN-1];
    div_diff_s = div_hi_s - {1'b0, bmag_r};
    if (op_r[2]) begin
      if (!div_diff_s[XLEN]) begin
        work_nx_s = {div_diff_s[XLEN-1:0], work_r[XLEN-2:0], 1'b1};
      end else begin
        work_nx_s = {div_hi_s[XLEN-1:0], work_r[XLEN-2:0], 1'b0};
      end
    end else begin
      work_nx_s = {mul_sum_s, work_r[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the final iteration
  always_comb begin
    prod_s = neg_r ? -work_nx_s : work_nx_s;
    quo_s  = work_nx_s[XLEN-1:0];
    rem_s  = work_nx_s[2*XLEN-1:XLEN];
    case (op_r)
      OP_MUL:                        result_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result_s = divz_r ? {XLEN{1'b1}} : (neg_r ? -quo_s : quo_s);
      OP_REM, OP_REMU:               result_s = neg_r ? -rem_s : rem_s;
      default:                       result_s = prod_s[XLEN-1:0];
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = RUN;
        end
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      op_r   <= 3'b000;
      rd_r   <= 5'd0;
      neg_r  <= 1'b0;
      divz_r <= 1'b0;
      bmag_r <= {XLEN{1'b0}};
      work_r <= {(2*XLEN){1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      we_r   <= 1'b0;
      rw_r   <= 5'd0;
      din_r  <= {XLEN{1'b0}};
    end else begin
      done_r <= 1'b0;
      we_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r  <= {CW{1'b0}};
            op_r   <= op;
            rd_r   <= rd;
            neg_r  <= neg_s;
            divz_r <= (b == {XLEN{1'b0}});
            bmag_r <= bmag_s;
            work_r <= {{XLEN{1'b0}}, amag_s};
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          work_r <= work_nx_s;
          cnt_r  <= cnt_r + CW'(1);
          if (last_s) begin
            din_r  <= result_s;
            rw_r   <= rd_r;
            done_r <= 1'b1;
            we_r   <= (rd_r != 5'd0);
          end
        end
        FIN:     busy_r <= 1'b0;
        default: busy_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-exact timeline checks against an
// arithmetic reference model, directed corner cases, randomized ops and reset abort.
module tb_muldiv_unit;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      rw;
  logic [XLEN-1:0] din;

  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] last_din;
  logic [4:0]      last_rw;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .busy(busy), .done(done), .we(we), .rw(rw), .din(din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] sx, sy, suy;
    logic [127:0]        ux, uy, p;
    logic signed [63:0]  q;
    logic [63:0]         ones, minv;
    sx   = {{64{x[63]}}, x};
    sy   = {{64{y[63]}}, y};
    ux   = {64'd0, x};
    uy   = {64'd0, y};
    suy  = uy;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    minv = 64'h8000_0000_0000_0000;
    model = 64'd0;
    case (o)
      3'd0: begin p = sx * sy;  model = p[63:0];   end
      3'd1: begin p = sx * sy;  model = p[127:64]; end
      3'd2: begin p = sx * suy; model = p[127:64]; end
      3'd3: begin p = ux * uy;  model = p[127:64]; end
      3'd4: begin
        if (y == 64'd0) model = ones;
        else if (x == minv && y == ones) model = minv;
        else begin q = $signed(x) / $signed(y); model = q; end
      end
      3'd5: model = (y == 64'd0) ? ones : x / y;
      3'd6: begin
        if (y == 64'd0) model = x;
        else if (x == minv && y == ones) model = 64'd0;
        else begin q = $signed(x) % $signed(y); model = q; end
      end
      default: model = (y == 64'd0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue at the current (post-negedge) time, check every cycle up to XLEN+2, return at a negedge.
  task automatic issue_and_check(input string name, input logic [2:0] o, input logic [63:0] x,
                                 input logic [63:0] y, input logic [4:0] r, input logic [63:0] expv,
                                 input bit scramble);
    start = 1'b1; op = o; a = x; b = y; rd = r;
    @(posedge clk);
    for (int cyc = 1; cyc <= XLEN + 1; cyc++) begin
      @(negedge clk);
      if (scramble) begin
        start = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op = 3'($urandom); rd = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL %s busy cyc %0d got %b exp 1", name, cyc, busy);
      end
      checks++;
      if (done !== (cyc == XLEN + 1)) begin
        failures++; $display("FAIL %s done cyc %0d got %b exp %b", name, cyc, done, cyc == XLEN + 1);
      end
      if (cyc <= XLEN) begin
        checks++;
        if (we !== 1'b0 || din !== last_din || rw !== last_rw) begin
          failures++;
          $display("FAIL %s hold cyc %0d got we=%b rw=%0d din=%h exp we=0 rw=%0d din=%h",
                   name, cyc, we, rw, din, last_rw, last_din);
        end
      end else begin
        checks++;
        if (din !== expv) begin
          failures++; $display("FAIL %s din got %h exp %h", name, din, expv);
        end
        checks++;
        if (rw !== r) begin
          failures++; $display("FAIL %s rw got %0d exp %0d", name, rw, r);
        end
        checks++;
        if (we !== (r != 5'd0)) begin
          failures++; $display("FAIL %s we got %b exp %b", name, we, r != 5'd0);
        end
      end
    end
    last_din = expv;
    last_rw  = r;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || din !== last_din || rw !== last_rw) begin
      failures++;
      $display("FAIL %s after got busy=%b done=%b we=%b din=%h rw=%0d exp 0 0 0 %h %0d",
               name, busy, done, we, din, rw, last_din, last_rw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 64'd0; b = 64'd0; rd = 5'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done got %b exp 0", done); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset we got %b exp 0", we); end
    checks++; if (rw !== 5'd0) begin failures++; $display("FAIL reset rw got %0d exp 0", rw); end
    checks++; if (din !== 64'd0) begin failures++; $display("FAIL reset din got %h exp 0", din); end
    last_din = 64'd0;
    last_rw  = 5'd0;
    rst = 1'b0;
    issue_and_check("mul_basic", 3'd0, 64'd234, 64'd672, 5'd18, 64'd157248, 1'b0);
  endtask

  task automatic test_directed();
    issue_and_check("mulhu_ones",  3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    issue_and_check("mulh_ones",   3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'd0, 1'b0);
    issue_and_check("mulhsu_neg",  3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue_and_check("div_neg",     3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    issue_and_check("rem_neg",     3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue_and_check("divu",        3'd5, 64'd672, 64'd18, 5'd6, 64'd37, 1'b0);
    issue_and_check("remu",        3'd7, 64'd672, 64'd18, 5'd7, 64'd6, 1'b0);
    issue_and_check("div_zero",    3'd4, 64'd100, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue_and_check("rem_zero",    3'd6, 64'd100, 64'd0, 5'd9, 64'd100, 1'b0);
    issue_and_check("div_ovf",     3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'h8000_0000_0000_0000, 1'b0);
    issue_and_check("rem_ovf",     3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0, 1'b0);
    issue_and_check("divu_zero",   3'd5, 64'd55, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue_and_check("remu_zero",   3'd7, 64'hFEDC_BA98_7654_3210, 64'd0, 5'd13, 64'hFEDC_BA98_7654_3210, 1'b0);
  endtask

  task automatic test_busy_ignore();
    issue_and_check("held_start", 3'd0, 64'd234, 64'd672, 5'd18, 64'd157248, 1'b1);
    issue_and_check("rd_zero", 3'd5, 64'd1000, 64'd7, 5'd0, 64'd142, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [63:0] x, y;
    logic [4:0]  r;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = rnd_operand();
      y = rnd_operand();
      r = 5'($urandom);
      issue_and_check("rand", o, x, y, r, model(o, x, y), 1'b0);
    end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; op = 3'd0; a = 64'd1234567; b = 64'd7654321; rd = 5'd5;
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 30) rst = 1'b1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL abort busy cyc %0d got %b exp 1", cyc, busy); end
    end
    last_din = 64'd0;
    last_rw  = 5'd0;
    for (int cyc = 31; cyc <= 130; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0 || din !== 64'd0 || rw !== 5'd0) begin
        failures++;
        $display("FAIL abort quiet cyc %0d got busy=%b done=%b we=%b din=%h rw=%0d exp all 0",
                 cyc, busy, done, we, din, rw);
      end
    end
    issue_and_check("after_abort", 3'd0, 64'd1234567, 64'd7654321, 5'd5, 64'd9449772114007, 1'b0);
  endtask

  task automatic test_back_to_back();
    issue_and_check("b2b_0", 3'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd20, model(3'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 1'b0);
    issue_and_check("b2b_1", 3'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd21, model(3'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
